// File: rtl/lc3_mem_pkg.sv
// Shared types and defaults for the LC3 main-memory block.
package lc3_mem_pkg;

    localparam int unsigned LC3_WORD_W         = 16;
    localparam int unsigned LC3_RAM_DEPTH_LOG2 = 15;
    localparam int unsigned LC3_WAIT_CNT_W     = 4;
    localparam string       LC3_INIT_FILE      = "MEMORY_INIT.v";

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/lc3_sp_ram.sv
// Single-port synchronous RAM with registered read port; infers block RAM.
// Read data holds until the next enabled read.
module lc3_sp_ram #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH_LOG2 = 15,
    parameter string       INIT_FILE  = ""
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic                  i_en,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [DATA_W-1:0]     i_din,
    output logic [DATA_W-1:0]     o_dout
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_din;
            end else begin
                o_dout <= r_mem[i_addr];
            end
        end
    end

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC3 main memory: request latching, wait-state sequencing, range check and
// a one-cycle ready pulse per completed access towards the microsequencer.
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int unsigned DATA_W      = LC3_WORD_W,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DEPTH_LOG2  = LC3_RAM_DEPTH_LOG2,
    parameter int unsigned WAIT_STATES = 0,
    parameter string       INIT_FILE   = LC3_INIT_FILE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_mem_en,
    input  logic              i_r_w,
    input  logic [ADDR_W-1:0] i_mar,
    input  logic [DATA_W-1:0] i_mdr,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_r,
    output logic              o_busy,
    output logic              o_addr_err
);

    localparam int unsigned CW = LC3_WAIT_CNT_W;
    localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_STATES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam bit SINGLE_CYCLE = (WAIT_STATES == 0);

    mem_state_t        r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_rw;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_mdr;
    logic              r_dout_zero;

    logic              w_idle;
    logic              w_access;
    logic              w_rw;
    logic              w_oor;
    logic              w_ram_en;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_din;
    logic [DATA_W-1:0] w_ram_dout;

    // In IDLE the live inputs feed the array so a zero-wait access can
    // complete on its request edge; afterwards only the latched copies count.
    assign w_idle   = (r_state == S_IDLE);
    assign w_access = (w_idle && i_mem_en && SINGLE_CYCLE) ||
                      ((r_state == S_WAIT) && (r_cnt == '0));
    assign w_rw     = w_idle ? i_r_w : r_rw;
    assign w_addr   = w_idle ? i_mar : r_mar;
    assign w_din    = w_idle ? i_mdr : r_mdr;

    generate
        if (DEPTH_LOG2 < ADDR_W) begin : g_range
            assign w_oor = |w_addr[ADDR_W-1:DEPTH_LOG2];
        end else begin : g_full
            assign w_oor = 1'b0;
        end
    endgenerate

    // A reset on the access edge must suppress the array write.
    assign w_ram_en = w_access && !w_oor && rst_n;

    lc3_sp_ram #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk    (clk),
        .i_we   (w_rw),
        .i_en   (w_ram_en),
        .i_addr (w_addr[DEPTH_LOG2-1:0]),
        .i_din  (w_din),
        .o_dout (w_ram_dout)
    );

    // Array output register has no reset; mask it after reset or a bad-address read.
    assign o_dout = r_dout_zero ? '0 : w_ram_dout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rw        <= 1'b0;
            r_mar       <= '0;
            r_mdr       <= '0;
            r_dout_zero <= 1'b1;
            o_r         <= 1'b0;
            o_busy      <= 1'b0;
            o_addr_err  <= 1'b0;
        end else begin
            o_r        <= 1'b0;
            o_addr_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_mem_en) begin
                        r_rw   <= i_r_w;
                        r_mar  <= i_mar;
                        r_mdr  <= i_mdr;
                        o_busy <= 1'b1;
                        if (SINGLE_CYCLE) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= WAIT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
            if (w_access) begin
                o_r        <= 1'b1;
                o_addr_err <= w_oor;
                if (!w_rw) begin
                    r_dout_zero <= w_oor;
                end
            end
        end
    end

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Scoreboard bench for lc3_mem_ctrl: two instances (0 and 3 wait states)
// against an address-keyed memory model with cycle-accurate ready timing.
module tb_lc3_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_en   [2];
    logic        r_w      [2];
    logic [15:0] mar      [2];
    logic [15:0] mdr      [2];
    logic [15:0] dout     [2];
    logic        r        [2];
    logic        busy     [2];
    logic        addr_err [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        lc3_mem_ctrl #(
            .WAIT_STATES ((g == 0) ? 0 : 3),
            .INIT_FILE   ("")
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_mem_en   (mem_en[g]),
            .i_r_w      (r_w[g]),
            .i_mar      (mar[g]),
            .i_mdr      (mdr[g]),
            .o_dout     (dout[g]),
            .o_r        (r[g]),
            .o_busy     (busy[g]),
            .o_addr_err (addr_err[g])
        );
    end

    typedef struct {
        bit          rd;
        bit          oor;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        sbq [2][$];
    logic [15:0] ref_mem [int unsigned];
    int unsigned pool [2][$];
    logic [15:0] exp_dout [2];
    int          cyc = 0;
    bit          rst_q = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic int ws(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s dut%0d got=%0h want=%0h cyc=%0d", nm, i, act, want, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst_n;
    end

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (!rst_q) exp_dout[i] = '0;
            if (r[i]) begin
                if (sbq[i].size() == 0) begin
                    chk("unexpected_r", i, 32'(r[i]), 32'd0);
                end else begin
                    e = sbq[i].pop_front();
                    chk("r_cycle", i, e.cyc, cyc);
                    chk("addr_err", i, 32'(addr_err[i]), 32'(e.oor));
                    chk("busy_with_r", i, 32'(busy[i]), 32'd1);
                    if (e.rd) exp_dout[i] = e.data;
                    chk("dout", i, 32'(dout[i]), 32'(exp_dout[i]));
                end
            end else if (addr_err[i]) begin
                chk("addr_err_no_r", i, 32'(addr_err[i]), 32'd0);
            end
        end
    end

    function automatic exp_t model(input int i, input bit wr, input logic [15:0] a,
                                   input logic [15:0] d, input int issue_cyc);
        exp_t e;
        int unsigned key = 32'(i) * 32'd65536 + 32'(a);
        e.rd   = !wr;
        e.oor  = (a >= 16'h8000);
        e.cyc  = issue_cyc + 1 + ws(i);
        e.data = 16'h0000;
        if (!e.oor) begin
            if (wr) begin
                ref_mem[key] = d;
                pool[i].push_back(32'(a));
            end else begin
                e.data = ref_mem[key];
            end
        end
        return e;
    endfunction

    // Issue one access at an idle negedge; returns at the next idle negedge.
    task automatic issue(input int i, input bit wr, input logic [15:0] a, input logic [15:0] d);
        chk("idle_busy", i, 32'(busy[i]), 32'd0);
        mem_en[i] = 1'b1;
        r_w[i]    = wr;
        mar[i]    = a;
        mdr[i]    = d;
        sbq[i].push_back(model(i, wr, a, d, cyc));
        for (int j = 1; j <= ws(i) + 1; j++) begin
            @(negedge clk);
            if (j == 1) begin
                mem_en[i] = 1'b0;
                r_w[i]    = 1'($urandom);
                mar[i]    = 16'($urandom);
                mdr[i]    = 16'($urandom);
            end
            chk("busy", i, 32'(busy[i]), 32'd1);
        end
        @(negedge clk);
    endtask

    task automatic check_quiet(input int i, input string nm);
        chk({nm, "_r"}, i, 32'(r[i]), 32'd0);
        chk({nm, "_busy"}, i, 32'(busy[i]), 32'd0);
        chk({nm, "_addr_err"}, i, 32'(addr_err[i]), 32'd0);
        chk({nm, "_dout"}, i, 32'(dout[i]), 32'd0);
    endtask

    initial begin
        int          sel;
        int          n;
        logic [15:0] a;
        for (int i = 0; i < 2; i++) begin
            mem_en[i] = 1'b0;
            r_w[i]    = 1'b0;
            mar[i]    = '0;
            mdr[i]    = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) check_quiet(i, "reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single-cycle write then read-back.
        issue(0, 1'b1, 16'h3000, 16'h1234);
        issue(0, 1'b0, 16'h3000, 16'h0000);

        for (int i = 0; i < 2; i++) begin
            issue(i, 1'b1, 16'h0010, 16'hABCD);
            issue(i, 1'b1, 16'h0020, 16'h1357);
            issue(i, 1'b1, 16'h7E00, 16'h2468);
        end

        // Three wait states: ready only on the fourth cycle.
        issue(1, 1'b0, 16'h0010, 16'h0000);

        // Request held high: one access per two cycles, none started in DONE.
        n = 6;
        chk("stream_idle", 0, 32'(busy[0]), 32'd0);
        mem_en[0] = 1'b1;
        r_w[0]    = 1'b0;
        mar[0]    = 16'h7E00;
        for (int j = 0; j < n; j++) sbq[0].push_back(model(0, 1'b0, 16'h7E00, 16'h0, cyc + 2 * j));
        repeat (2 * n) @(negedge clk);
        mem_en[0] = 1'b0;
        @(negedge clk);

        // Out-of-range accesses must neither write nor alias.
        for (int i = 0; i < 2; i++) begin
            issue(i, 1'b1, 16'hFE00, 16'h5555);
            issue(i, 1'b0, 16'hFE00, 16'h0000);
            issue(i, 1'b0, 16'h7E00, 16'h0000);
        end

        // Reset in the second wait cycle aborts a write.
        mem_en[1] = 1'b1;
        r_w[1]    = 1'b1;
        mar[1]    = 16'h0020;
        mdr[1]    = 16'hBEEF;
        @(negedge clk);
        mem_en[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) check_quiet(i, "abort");
        @(negedge clk);
        issue(1, 1'b0, 16'h0020, 16'h0000);

        // Reset landing while r is high.
        sbq[0].push_back(model(0, 1'b0, 16'h0010, 16'h0, cyc));
        mem_en[0] = 1'b1;
        r_w[0]    = 1'b0;
        mar[0]    = 16'h0010;
        @(negedge clk);
        mem_en[0] = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        check_quiet(0, "rst_done");
        rst_n = 1'b1;
        @(negedge clk);

        // Reset and request on the same edge: request dropped.
        rst_n     = 1'b0;
        mem_en[0] = 1'b1;
        r_w[0]    = 1'b1;
        mar[0]    = 16'h0020;
        mdr[0]    = 16'hDEAD;
        @(negedge clk);
        rst_n     = 1'b1;
        mem_en[0] = 1'b0;
        chk("rst_req_busy", 0, 32'(busy[0]), 32'd0);
        @(negedge clk);
        chk("rst_req_busy2", 0, 32'(busy[0]), 32'd0);
        issue(0, 1'b0, 16'h0020, 16'h0000);

        // Randomised mix against the model.
        for (int k = 0; k < 80; k++) begin
            int inst = int'($urandom_range(1));
            sel = int'($urandom_range(7));
            if (sel == 0) begin
                issue(inst, 1'($urandom), 16'h8000 | 16'($urandom), 16'($urandom));
            end else if (sel <= 3) begin
                issue(inst, 1'b1, 16'($urandom_range(16'h7FFF)), 16'($urandom));
            end else begin
                a = 16'(pool[inst][$urandom_range(pool[inst].size() - 1)]);
                issue(inst, 1'b0, a, 16'($urandom));
            end
        end

        repeat (8) @(negedge clk);
        for (int i = 0; i < 2; i++) chk("sb_drain", i, 32'(sbq[i].size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
